// File: rtl/score_matrix_pkg.sv
// rtl/score_matrix_pkg.sv - shared constants, index-width helper and types for the score matrix
//
// Default geometry is 10 rows x 10 columns x 2-bit elements. The types below
// describe that default geometry; parametrised modules derive their own widths
// from ROWS/COLS/W.
package score_matrix_pkg;

  localparam int ROWS_DEF = 10;
  localparam int COLS_DEF = 10;
  localparam int W_DEF    = 2;

  // Width of a column index. Never drops below 1 bit so a port can always
  // be declared.
  function automatic int col_idx_w(input int cols);
    return (cols > 1) ? $clog2(cols) : 1;
  endfunction

  typedef logic [W_DEF-1:0]                          elem_t;
  typedef logic [ROWS_DEF-1:0][W_DEF-1:0]            column_t;
  typedef logic [ROWS_DEF-1:0][COLS_DEF-1:0][W_DEF-1:0] matrix_t;

endpackage

// File: rtl/score_matrix_bank.sv
// rtl/score_matrix_bank.sv - one matrix bank: storage, written-column mask and full flag
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   wr_en      accepted in-range column write aimed at this bank
//   wr_col     column index of the write
//   wr_data    column contents, row r = wr_data[r]
//   rel        consumer releases this (full) bank
//   full       bank holds a complete matrix
//   complete   combinational: this write completes the matrix
//   dup_hit    combinational: this write hits an already-written column
//              (present only with SCORE_MATRIX_DUP_CHECK_EN)
//   matrix     bank contents, [row][col][bit]
module score_matrix_bank
  import score_matrix_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF,
  parameter int W    = W_DEF
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               wr_en,
  input  logic [col_idx_w(COLS)-1:0]         wr_col,
  input  logic [ROWS-1:0][W-1:0]             wr_data,
  input  logic                               rel,
  output logic                               full,
  output logic                               complete,
`ifdef SCORE_MATRIX_DUP_CHECK_EN
  output logic                               dup_hit,
`endif
  output logic [ROWS-1:0][COLS-1:0][W-1:0]   matrix
);

  logic [COLS-1:0] mask;
  logic [COLS-1:0] col_onehot;

  // Explicit compare loop keeps out-of-range indices from selecting anything.
  always_comb begin
    col_onehot = '0;
    for (int c = 0; c < COLS; c++) begin
      col_onehot[c] = (int'(wr_col) == c);
    end
  end

  // A rewrite of an already-set bit cannot complete the round: the OR adds nothing.
  assign complete = wr_en && ((mask | col_onehot) == {COLS{1'b1}});

`ifdef SCORE_MATRIX_DUP_CHECK_EN
  assign dup_hit = wr_en && |(mask & col_onehot);
`endif

  // The top only writes a non-full bank and only releases a full one, so
  // rel and wr_en never act on the same bank in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      matrix <= '0;
      mask   <= '0;
      full   <= 1'b0;
    end else begin
      if (wr_en) begin
        for (int c = 0; c < COLS; c++) begin
          if (col_onehot[c]) begin
            for (int r = 0; r < ROWS; r++) begin
              matrix[r][c] <= wr_data[r];
            end
          end
        end
        mask <= complete ? '0 : (mask | col_onehot);
        if (complete) full <= 1'b1;
      end
      if (rel) full <= 1'b0;
    end
  end

endmodule

// File: rtl/score_matrix_pingpong.sv
// rtl/score_matrix_pingpong.sv - double-buffered column-write scoring matrix with valid/ready read port
//
// Optional feature macro: SCORE_MATRIX_DUP_CHECK_EN (duplicate-column write detection).
//
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   wr_valid    column write request
//   wr_ready    write bank can accept a column
//   wr_col      target column index
//   wr_data     column contents, row r = wr_data[r]
//   rd_valid    completed matrix available on matrix_out
//   rd_ready    consumer releases the presented matrix
//   rd_bank     bank shown on matrix_out
//   matrix_out  read bank contents, [row][col][bit]
//   col_err     one-cycle pulse after an accepted write with wr_col >= COLS
//   dup_err     one-cycle pulse after an accepted write to an already-written column
module score_matrix_pingpong
  import score_matrix_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF,
  parameter int W    = W_DEF
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               wr_valid,
  output logic                               wr_ready,
  input  logic [col_idx_w(COLS)-1:0]         wr_col,
  input  logic [ROWS-1:0][W-1:0]             wr_data,
  output logic                               rd_valid,
  input  logic                               rd_ready,
  output logic                               rd_bank,
  output logic [ROWS-1:0][COLS-1:0][W-1:0]   matrix_out,
  output logic                               col_err,
  output logic                               dup_err
);

  logic       wp;
  logic       rp;
  logic [1:0] full;
  logic [1:0] complete;
  logic [1:0] wr_en;
  logic [1:0] rel;
  logic       wr_acc;
  logic       col_ok;
  logic       rd_acc;
  logic [ROWS-1:0][COLS-1:0][W-1:0] bank_mat [2];

  // Handshake flags decode registered state only.
  assign wr_ready = !full[wp];
  assign rd_valid = full[rp];
  assign rd_bank  = rp;
  assign matrix_out = bank_mat[rp];

  assign wr_acc = wr_valid && wr_ready;
  assign col_ok = int'(wr_col) < COLS;
  assign rd_acc = rd_valid && rd_ready;

`ifdef SCORE_MATRIX_DUP_CHECK_EN
  logic [1:0] dup_hit;
`endif

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign wr_en[b] = wr_acc && col_ok && (wp == 1'(b));
    assign rel[b]   = rd_acc && (rp == 1'(b));

    score_matrix_bank #(
      .ROWS (ROWS),
      .COLS (COLS),
      .W    (W)
    ) u_bank (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en[b]),
      .wr_col   (wr_col),
      .wr_data  (wr_data),
      .rel      (rel[b]),
      .full     (full[b]),
      .complete (complete[b]),
`ifdef SCORE_MATRIX_DUP_CHECK_EN
      .dup_hit  (dup_hit[b]),
`endif
      .matrix   (bank_mat[b])
    );
  end

  // Only the write bank can complete, so any completion flips wp.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp      <= 1'b0;
      rp      <= 1'b0;
      col_err <= 1'b0;
    end else begin
      if (|complete) wp <= ~wp;
      if (rd_acc)    rp <= ~rp;
      col_err <= wr_acc && !col_ok;
    end
  end

`ifdef SCORE_MATRIX_DUP_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) dup_err <= 1'b0;
    else     dup_err <= |dup_hit;
  end
`else
  assign dup_err = 1'b0;
`endif

endmodule

// File: tb/tb_score_matrix_pingpong.sv
// tb/tb_score_matrix_pingpong.sv - self-checking bench for score_matrix_pingpong
module tb_score_matrix_pingpong;

  localparam int ROWS = 10;
  localparam int COLS = 10;
  localparam int W    = 2;
  localparam int CW   = 4;
  localparam int MW   = ROWS * COLS * W;
  localparam int DW   = ROWS * W;
`ifdef SCORE_MATRIX_DUP_CHECK_EN
  localparam bit DUP_EN = 1'b1;
`else
  localparam bit DUP_EN = 1'b0;
`endif

  logic                             clk = 1'b0;
  logic                             rst;
  logic                             wr_valid;
  logic                             wr_ready;
  logic [CW-1:0]                    wr_col;
  logic [ROWS-1:0][W-1:0]           wr_data;
  logic                             rd_valid;
  logic                             rd_ready;
  logic                             rd_bank;
  logic [ROWS-1:0][COLS-1:0][W-1:0] matrix_out;
  logic                             col_err;
  logic                             dup_err;

  score_matrix_pingpong #(.ROWS(ROWS), .COLS(COLS), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_col     (wr_col),
    .wr_data    (wr_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_bank    (rd_bank),
    .matrix_out (matrix_out),
    .col_err    (col_err),
    .dup_err    (dup_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: contents of each bank, how many matrices are waiting,
  // how many rounds completed / matrices released, columns written this round.
  int mbank [2][ROWS][COLS];
  int pending;
  int rounds;
  int releases;
  bit written [COLS];
  bit exp_col_err;
  bit exp_dup_err;

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) mbank[b][r][c] = 0;
    for (int c = 0; c < COLS; c++) written[c] = 0;
    pending = 0; rounds = 0; releases = 0;
    exp_col_err = 0; exp_dup_err = 0;
  endtask

  task automatic model_step(input bit v, input int col, input logic [DW-1:0] d, input bit rr);
    bit acc, rel, done;
    int wb;
    acc  = v && (pending < 2);
    rel  = rr && (pending > 0);
    wb   = rounds % 2;
    done = 0;
    exp_col_err = acc && (col >= COLS);
    exp_dup_err = 0;
    if (acc && col < COLS) begin
      exp_dup_err = DUP_EN && written[col];
      for (int r = 0; r < ROWS; r++) mbank[wb][r][col] = int'(d[r*W +: W]);
      written[col] = 1;
      done = 1;
      for (int c = 0; c < COLS; c++) if (!written[c]) done = 0;
    end
    if (done) begin
      for (int c = 0; c < COLS; c++) written[c] = 0;
      rounds++;
      pending++;
    end
    if (rel) begin
      releases++;
      pending--;
    end
  endtask

  function automatic logic [MW-1:0] exp_matrix();
    logic [MW-1:0] m;
    int b;
    int v;
    b = releases % 2;
    m = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        v = mbank[b][r][c];
        m[(r*COLS+c)*W +: W] = v[W-1:0];
      end
    return m;
  endfunction

  task automatic chk(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".wr_ready"},   MW'(wr_ready),   MW'(pending < 2));
    chk({tag, ".rd_valid"},   MW'(rd_valid),   MW'(pending > 0));
    chk({tag, ".rd_bank"},    MW'(rd_bank),    MW'(releases % 2));
    chk({tag, ".matrix_out"}, matrix_out,      exp_matrix());
    chk({tag, ".col_err"},    MW'(col_err),    MW'(exp_col_err));
    chk({tag, ".dup_err"},    MW'(dup_err),    MW'(exp_dup_err));
  endtask

  task automatic cycle(input string tag, input bit v, input int col, input logic [DW-1:0] d, input bit rr);
    wr_valid = v;
    wr_col   = CW'(col);
    wr_data  = d;
    rd_ready = rr;
    model_step(v, col, d, rr);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    @(posedge clk); #1;
    model_reset();
    rst = 1'b0;
    check_all("reset");
  endtask

  function automatic logic [DW-1:0] pattern(input int c);
    logic [DW-1:0] d;
    int v;
    for (int r = 0; r < ROWS; r++) begin
      v = (10 * c + r) & 3;
      d[r*W +: W] = v[W-1:0];
    end
    return d;
  endfunction

  function automatic logic [DW-1:0] rnd_col();
    return DW'($urandom);
  endfunction

  logic [MW-1:0] held;
  int order [COLS];

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_col = '0; wr_data = '0; rd_ready = 1'b0;
    model_reset();
    @(posedge clk); #1;

    // Reset then idle.
    do_reset();
    chk("reset.matrix_zero", matrix_out, '0);
    for (int i = 0; i < 3; i++) begin
      cycle("idle", 0, 0, '0, 0);
      chk("idle.wr_ready", MW'(wr_ready), MW'(1));
    end

    // First round, in order, into bank 0.
    for (int c = 0; c < COLS; c++) begin
      cycle("fill0", 1, c, pattern(c), 0);
      chk("fill0.rd_valid", MW'(rd_valid), MW'(c == COLS - 1));
    end
    chk("fill0.rd_bank", MW'(rd_bank), MW'(0));

    // Ping-pong: bank 1 filled in reverse while bank 0 waits unread.
    held = matrix_out;
    for (int c = COLS - 1; c >= 0; c--) begin
      cycle("fill1", 1, c, rnd_col(), 0);
      chk("fill1.matrix_stable", matrix_out, held);
    end
    chk("fill1.wr_ready_low", MW'(wr_ready), MW'(0));
    cycle("stall", 1, 4, rnd_col(), 0);
    chk("stall.matrix_stable", matrix_out, held);
    cycle("rel0", 0, 0, '0, 1);
    chk("rel0.rd_bank", MW'(rd_bank), MW'(1));
    chk("rel0.rd_valid", MW'(rd_valid), MW'(1));
    chk("rel0.wr_ready", MW'(wr_ready), MW'(1));

    // Release and completion on the same edge.
    cycle("rel1", 0, 0, '0, 1);
    for (int c = 0; c < COLS; c++) cycle("fillb0", 1, c, rnd_col(), 0);
    for (int c = 0; c < COLS - 1; c++) cycle("fillb1", 1, c, rnd_col(), 0);
    cycle("both", 1, COLS - 1, rnd_col(), 1);
    chk("both.rd_valid", MW'(rd_valid), MW'(1));
    chk("both.rd_bank", MW'(rd_bank), MW'(1));
    chk("both.wr_ready", MW'(wr_ready), MW'(1));
    cycle("rel2", 0, 0, '0, 1);

    // Error paths: out-of-range column, then a duplicate column.
    cycle("colerr", 1, 12, rnd_col(), 0);
    chk("colerr.pulse", MW'(col_err), MW'(1));
    cycle("colerr.idle", 0, 0, '0, 0);
    chk("colerr.clear", MW'(col_err), MW'(0));
    cycle("dup.first", 1, 3, {ROWS{2'b01}}, 0);
    cycle("dup.second", 1, 3, {ROWS{2'b10}}, 0);
    chk("dup.pulse", MW'(dup_err), MW'(DUP_EN));
    order = '{0, 1, 2, 4, 5, 6, 7, 8, 9, 9};
    for (int i = 0; i < COLS - 1; i++) begin
      cycle("dup.fill", 1, order[i], rnd_col(), 0);
      chk("dup.rd_valid", MW'(rd_valid), MW'(i == COLS - 2));
    end
    chk("dup.col3_holds_2", MW'(matrix_out[5][3]), MW'(2));
    cycle("rel3", 0, 0, '0, 1);

    // Reset mid-round, then a fresh round into bank 0.
    for (int c = 0; c < 5; c++) cycle("partial", 1, c, rnd_col(), 0);
    do_reset();
    chk("midreset.matrix_zero", matrix_out, '0);
    chk("midreset.rd_valid", MW'(rd_valid), MW'(0));
    for (int c = 0; c < COLS; c++) cycle("fresh", 1, c, pattern(c), 0);
    chk("fresh.rd_valid", MW'(rd_valid), MW'(1));
    chk("fresh.rd_bank", MW'(rd_bank), MW'(0));

    // Randomised traffic against the model.
    for (int i = 0; i < 500; i++) begin
      cycle("rand", ($urandom_range(0, 9) < 7), $urandom_range(0, 11), rnd_col(),
            ($urandom_range(0, 9) < 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/score_matrix_pingpong.md
# score_matrix_pingpong

Double-buffered, parametrised successor to the single-bank scoring matrix. Column vectors are written by index into a write bank; when every column of that bank has been written, the bank is handed to the downstream scorer through a valid/ready read port. Writing continues immediately into the second bank, so one matrix can be filled while the previous one is consumed.

## Interface
- ROWS, 10: rows per matrix, ≥1
- COLS, 10: columns per matrix, ≥2
- W, 2: bits per element, ≥1
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- wr_valid  in  1  column write request
- wr_ready  out  1  write bank can accept a column
- wr_col  in  $clog2(COLS)  target column index
- wr_data  in  ROWS×W, packed [ROWS-1:0][W-1:0]  column contents; row r = wr_data[r]
- rd_valid  out  1  completed matrix available
- rd_ready  in  1  consumer releases the presented matrix
- rd_bank  out  1  index of the bank presented on matrix_out
- matrix_out  out  ROWS×COLS×W, packed [ROWS-1:0][COLS-1:0][W-1:0]  contents of the read bank
- col_err  out  1  one-cycle pulse: accepted write had wr_col ≥ COLS
- dup_err  out  1  one-cycle pulse: accepted write hit a column already written this round

## Operation
- Two banks, each holding ROWS×COLS×W storage, a COLS-bit written mask and a full flag. Write pointer wp, read pointer rp.
- Write accept is wr_valid && wr_ready, with wr_ready = !full[wp].
- On an accepted write with wr_col < COLS: bank[wp] column wr_col ← wr_data, and mask[wp][wr_col] ← 1.
- If mask[wp] | onehot(wr_col) is all ones, then on the same edge: full[wp] ← 1, mask[wp] ← 0, wp ← ~wp.
- On an accepted write with wr_col ≥ COLS: storage and mask are unchanged, and col_err pulses.
- Read side: rd_valid = full[rp], rd_bank = rp, matrix_out = bank[rp] at all times. When rd_valid is low, the output shows the last/partial contents and must not be consumed.
- Release is rd_valid && rd_ready: full[rp] ← 0, rp ← ~rp. Bank contents are not cleared; the next round overwrites them.
- Simultaneous completion on one bank and release of the other are independent and both take effect.
- Both banks full: wr_ready = 0, and writes stall until a release. The write that fills the second bank is accepted normally.
- Writes never disturb a full bank, so matrix_out is stable while rd_valid = 1.
- Reset: all storage, masks and full flags cleared; wp = rp = 0.
  - Output reset values: wr_ready = 1, rd_valid = 0, rd_bank = 0, matrix_out = 0, col_err = 0, dup_err = 0.
  - Reset mid-round discards the partial round and any unread matrices.

## Timing
- wr_ready and rd_valid are registered-flag decodes, with no combinational path from wr_valid or rd_ready.
- Write-to-visible latency is 1 cycle. Completion on edge k gives rd_valid = 1 after edge k.
- Minimum round is COLS accepted writes. The next round may start on the cycle after completion; there are no bubbles.
- A release on edge k drops rd_valid after edge k, unless the other bank is full, in which case rd_bank toggles and rd_valid stays 1.
- col_err and dup_err are registered and assert the cycle after the offending accept, for exactly 1 cycle.

## Configuration
- SCORE_MATRIX_DUP_CHECK_EN defined: a write to an already-set mask bit overwrites the data and pulses dup_err. This includes the case where such a write completes the round (it cannot, since the mask is already counted).
- Macro undefined: the overwrite happens silently, dup_err is tied to 0, and its detection logic is absent.

## Structure
- Package score_matrix_pkg holds:
  - default constants ROWS_DEF, COLS_DEF, W_DEF
  - a column-index width helper function
  - typedefs for element, column and matrix, using the defaults
- Sub-module score_matrix_bank is instantiated twice. It contains storage, the written mask, the full flag, a completion detect output, and a release input.
- The top level owns wp/rp, handshakes, error pulses and output muxing.

## Test plan
All scenarios use ROWS = COLS = 10, W = 2.
- Reset then idle: all outputs zero, wr_ready = 1, across 3 idle cycles.
- Write cols 0..9 in order, with data[r] = (10c + r) & 3. Expect:
  - rd_valid = 0 after cols 0..8
  - rd_valid = 1, rd_bank = 0 after col 9
  - matrix_out[r][c] matches the written data
- Ping-pong: with bank 0 unread, write cols 9..0 into bank 1. Expect:
  - wr_ready = 0 afterwards
  - matrix_out unchanged throughout
  - rd_ready pulse → rd_bank = 1, rd_valid stays 1, wr_ready = 1
- Release and completion on the same edge: bank 0 full, last column of bank 1 written while rd_ready = 1. Expect rd_valid = 1, rd_bank = 1, wr_ready = 1.
- Error paths:
  - wr_col = 12: col_err pulse, mask and storage unchanged
  - col 3 written twice with data 1 then 2: matrix holds 2, and dup_err pulses only with SCORE_MATRIX_DUP_CHECK_EN
- Reset asserted after 5 columns of a round: all outputs return to reset values, and a fresh 10-column round completes normally in bank 0.
